// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Optional idle-grant timeout is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, SEND, WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [IDX_W-1:0]   arb_idx;
  logic [7:0]         tx_data_nxt;
  logic               last_flag, last_flag_nxt;
  logic               guard, guard_nxt;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               hs;
  logic               revoke;

  // First requester strictly after the previous owner, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!found && vld[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
    return pick;
  endfunction

  assign arb_idx = rr_pick(req_valid, last_grant);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Counts only starved XFER cycles; leaving XFER or any handshake restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != XFER || hs) begin
      to_cnt <= '0;
    end else if (!sel_valid && !revoke) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign revoke = (state == XFER) && !sel_valid && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign revoke = 1'b0;
`endif

  assign timeout_pulse = revoke;
  assign tx_valid      = (state == SEND);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gnt_idx_nxt    = gnt_idx;
    last_grant_nxt = last_grant;
    tx_data_nxt    = tx_data;
    last_flag_nxt  = last_flag;
    guard_nxt      = 1'b0;
    req_ready      = '0;
    hs             = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          gnt_idx_nxt = arb_idx;
          grant_nxt   = NUM_REQ'(1) << arb_idx;
          state_nxt   = XFER;
        end
      end
      XFER: begin
        hs        = sel_valid & ~tx_busy;
        req_ready = grant & {NUM_REQ{hs}};
        if (hs) begin
          tx_data_nxt   = sel_data;
          last_flag_nxt = sel_last;
          state_nxt     = SEND;
        end else if (revoke) begin
          grant_nxt      = '0;
          last_grant_nxt = gnt_idx;
          state_nxt      = IDLE;
        end
      end
      SEND: begin
        guard_nxt = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // The guard cycle gives the transmitter one clock to raise tx_busy.
        if (!guard && !tx_busy) begin
          if (last_flag) begin
            last_grant_nxt = gnt_idx;
            grant_nxt      = '0;
            state_nxt      = IDLE;
          end else begin
            state_nxt = XFER;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gnt_idx    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      tx_data    <= 8'h00;
      last_flag  <= 1'b0;
      guard      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gnt_idx    <= gnt_idx_nxt;
      last_grant <= last_grant_nxt;
      tx_data    <= tx_data_nxt;
      last_flag  <= last_flag_nxt;
      guard      <= guard_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a busy-counter transmitter model,
// with expected byte order computed from packet-level round-robin over the queued packets.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_busy, timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .grant(grant), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [8:0] bq [N][$];
  logic [8:0] cp [N][$];
  logic       mid [N];
  int         stall_left [N];
  int         force_stall [N];
  int         busy_len = 0, busy_left = 0;
  bit         rand_stall = 0, hold_chk = 0;
  int         hold_n = 0, pulse_total = 0;
  int         model_last = N - 1;
  int         expq [$];
  int         rdy_log [$], stb_log [$], pulse_log [$];
  logic [N-1:0] glog [$];
  int         t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit any_pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (bq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic add_pkt(input int r, input int len, input bit rnd, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom) : base + 8'(k);
      bq[r].push_back({(k == len - 1), b});
    end
  endtask

  // Reference ordering: whole packets, next owner is the first requester after the previous one with data.
  task automatic build_expected();
    int pick;
    bit done;
    logic [8:0] b;
    for (int i = 0; i < N; i++) cp[i] = bq[i];
    done = 0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && cp[(model_last + k) % N].size() > 0) pick = (model_last + k) % N;
      if (pick < 0) done = 1;
      else begin
        b = 9'h000;
        while (!b[8]) begin
          b = cp[pick].pop_front();
          expq.push_back(pick * 256 + int'(b[7:0]));
        end
        model_last = pick;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0 && !(mid[i] && stall_left[i] > 0)) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = bq[i][0][7:0];
        req_last[i]       = bq[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
    tx_busy = (busy_left > 0);
  endtask

  task automatic tick();
    int e;
    bit lst;
    @(negedge clk);
    drive();
    #1;
    cyc++;
    glog.push_back(grant);
    if (timeout_pulse) begin
      pulse_log.push_back(cyc);
      pulse_total++;
    end
    if (hold_chk && mid[3] && stall_left[3] > 0) begin
      hold_n++;
      check("hold_grant", grant, 4'b1000);
      check("hold_no_req0_ready", req_ready[0], 1'b0);
    end
    if (tx_valid) begin
      stb_log.push_back(cyc);
      check("strobe_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("tx_data", tx_data, e % 256);
        check("strobe_owner", grant, 1 << (e / 256));
      end
    end
    if (busy_left > 0) busy_left--;
    if (tx_valid) busy_left = busy_len;
    for (int i = 0; i < N; i++) if (stall_left[i] > 0) stall_left[i]--;
    if (req_ready != '0) begin
      check("ready_onehot_granted", $onehot(req_ready) && ((req_ready & ~grant) == '0), 1);
      rdy_log.push_back(cyc);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && bq[i].size() > 0) begin
          lst    = bq[i][0][8];
          void'(bq[i].pop_front());
          mid[i] = !lst;
          if (!lst)
            stall_left[i] = (force_stall[i] >= 0) ? force_stall[i]
                                                  : (rand_stall ? int'($urandom_range(0, 8)) : 0);
          force_stall[i] = -1;
        end
      end
    end
  endtask

  task automatic clear_logs();
    rdy_log.delete(); stb_log.delete(); pulse_log.delete(); glog.delete();
    t0 = cyc + 1;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while ((expq.size() > 0 || any_pending() || grant != '0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_completed"}, n < budget, 1);
    check({tag, "_grant_idle"}, grant, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      mid[i] = 1'b0; stall_left[i] = 0; force_stall[i] = -1;
    end
    expq.delete();
    busy_left = 0; req_valid = '0; req_last = '0; tx_busy = 1'b0;
    #1;
    check("rst_grant", grant, '0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_timeout_pulse", timeout_pulse, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    model_last = N - 1;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      mid[i] = 1'b0; stall_left[i] = 0; force_stall[i] = -1;
    end
    do_reset();

    // Per-byte latency with an always-idle transmitter.
    busy_len = 0;
    add_pkt(0, 2, 0, 8'h10);
    build_expected();
    clear_logs();
    run_until_done(100, "latency");
    check("lat_ready0", rdy_log.size() >= 2 ? rdy_log[0] - t0 : -1, 1);
    check("lat_ready1", rdy_log.size() >= 2 ? rdy_log[1] - t0 : -1, 5);
    check("lat_strobe0", stb_log.size() >= 2 ? stb_log[0] - t0 : -1, 2);
    check("lat_strobe1", stb_log.size() >= 2 ? stb_log[1] - t0 : -1, 6);
    check("lat_grant_held", glog.size() >= 10 ? glog[8] : '0, 4'b0001);
    check("lat_grant_released", glog.size() >= 10 ? glog[9] : 4'hf, 4'b0000);

    // Back-to-back single-byte packets from one requester: one IDLE cycle between.
    add_pkt(0, 1, 0, 8'h20);
    add_pkt(0, 1, 0, 8'h21);
    build_expected();
    clear_logs();
    run_until_done(100, "b2b");
    check("b2b_strobe0", stb_log.size() >= 2 ? stb_log[0] - t0 : -1, 2);
    check("b2b_strobe1", stb_log.size() >= 2 ? stb_log[1] - t0 : -1, 7);
    check("b2b_idle_gap", glog.size() >= 7 ? glog[5] : 4'hf, 4'b0000);
    check("b2b_regrant", glog.size() >= 7 ? glog[6] : '0, 4'b0001);

    // Three-byte packet against a transmitter busy for 10 cycles per byte.
    busy_len = 10;
    add_pkt(0, 3, 0, 8'h41);
    build_expected();
    clear_logs();
    run_until_done(300, "pkt3");
    bad = 0;
    foreach (glog[k]) if (glog[k] != '0 && glog[k] != 4'b0001) bad++;
    check("pkt3_grant_only_r0", bad, 0);
    check("pkt3_strobes", stb_log.size(), 3);

    // Requesters 1 and 2 together: whole packets, no interleaving.
    busy_len = 3;
    add_pkt(1, 2, 0, 8'h60);
    add_pkt(2, 2, 0, 8'h70);
    build_expected();
    run_until_done(300, "pair");

    // All four continuously active with single-byte packets, starting from reset.
    do_reset();
    busy_len = 2;
    for (int r = 0; r < N; r++) begin
      add_pkt(r, 1, 0, 8'(8'h80 + 8'(r)));
      add_pkt(r, 1, 0, 8'(8'h90 + 8'(r)));
    end
    build_expected();
    run_until_done(400, "rr_all");

    // Randomized rounds with random packet sizes, bytes, busy times and short stalls.
    rand_stall = 1;
    for (int rnd = 0; rnd < 6; rnd++) begin
      busy_len = $urandom_range(0, 12);
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(1, 4), 1, 8'h00);
      end
      build_expected();
      run_until_done(4000, "random");
    end
    rand_stall = 0;

`ifdef UART_ARB_TIMEOUT_EN
    // Requester 2 stalls mid-packet; the grant is revoked and 3 then 0 are served.
    do_reset();
    busy_len = 0;
    add_pkt(1, 1, 0, 8'h11);
    build_expected();
    run_until_done(100, "to_setup");
    bq[2].push_back({1'b0, 8'h70});
    bq[2].push_back({1'b1, 8'h71});
    add_pkt(3, 1, 0, 8'h30);
    add_pkt(0, 1, 0, 8'h05);
    force_stall[2] = 1000;
    expq.push_back(2 * 256 + 8'h70);
    expq.push_back(3 * 256 + 8'h30);
    expq.push_back(0 * 256 + 8'h05);
    clear_logs();
    repeat (60) tick();
    check("to_pulse_count", pulse_log.size(), 1);
    check("to_pulse_time", (pulse_log.size() > 0 && stb_log.size() > 0) ? pulse_log[0] - stb_log[0] : -1, 23);
    check("to_strobes", stb_log.size(), 3);
    check("to_exp_drained", expq.size(), 0);
    if (pulse_log.size() > 0 && glog.size() > pulse_log[0] - t0 + 2) begin
      check("to_grant_dropped", glog[pulse_log[0] - t0 + 1], 4'b0000);
      check("to_next_owner", glog[pulse_log[0] - t0 + 2], 4'b1000);
    end
    check("to_pulse_total", pulse_total, 1);
    bq[2].delete(); mid[2] = 1'b0; stall_left[2] = 0;
    model_last = 0;
`else
    // Requester 3 stalls 50 cycles mid-packet while requester 0 waits.
    do_reset();
    busy_len = 0;
    add_pkt(2, 1, 0, 8'h22);
    build_expected();
    run_until_done(100, "hold_setup");
    add_pkt(3, 2, 0, 8'hd0);
    add_pkt(0, 1, 0, 8'ha0);
    force_stall[3] = 50;
    hold_chk = 1;
    hold_n   = 0;
    build_expected();
    run_until_done(400, "hold");
    hold_chk = 0;
    check("hold_cycles", hold_n, 50);
    check("no_timeout_pulse", pulse_total, 0);
`endif

    // Reset asserted while tx_valid is high.
    do_reset();
    busy_len = 0;
    bq[1].push_back({1'b0, 8'h55});
    bq[1].push_back({1'b1, 8'h56});
    expq.push_back(1 * 256 + 8'h55);
    clear_logs();
    for (int n = 0; n < 20 && stb_log.size() == 0; n++) tick();
    check("send_reached", stb_log.size(), 1);
    rst_n = 1'b0;
    #1;
    check("rst_send_tx_valid", tx_valid, 1'b0);
    check("rst_send_grant", grant, '0);
    check("rst_send_ready", req_ready, '0);
    do_reset();
    add_pkt(2, 1, 0, 8'h77);
    add_pkt(0, 1, 0, 8'h99);
    build_expected();
    run_until_done(100, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
